// File: rtl/uart_rx_peri.sv
// 8N1 UART receiver with a 16-byte FIFO, exposed as RXDATA/STATUS/CTRL registers on the peri bus.
// Latency: byte visible one cycle after the stop sample; bus response one cycle after the request edge.
module uart_rx_peri #(
    parameter int          BAUD_DIV  = 1085,
    parameter int          FIFO_AW   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    input  logic        peri_rden,
    input  logic        peri_wren,
    input  logic [31:0] peri_addr,
    input  logic [31:0] peri_wdata,
    output logic [31:0] peri_rdata,
    output logic        peri_ready,
    output logic        irq_rx
);
    localparam int            CW    = $clog2(BAUD_DIV);
    localparam int            DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0] HALF  = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULLB = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    rx_state_t        state_q, state_d;
    logic             rx_m, rx_s, rx_prev, armed;
    logic [1:0]       sync_fill;
    logic [CW-1:0]    cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             start_det, byte_ok, byte_bad;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, count;
    logic             nonempty, full, pop, do_push, overrun_set;
    logic             overrun, frame_err, irq_en;

    logic             pre_rden, pre_wren, rd_acc, wr_acc;
    logic             a_rxdata, a_status, a_ctrl, hit;
    logic [31:0]      rd_val;
    logic             unused_wdata;

    assign unused_wdata = ^{peri_wdata[31:4], peri_wdata[1]};

    // armed stays low until the synchronizer has flushed its reset value and seen a real idle-high line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rx_m      <= uart_rx;
            rx_s      <= rx_m;
            rx_prev   <= rx_s;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & rx_s);
        end
    end

    assign start_det = armed & ~rx_s & rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_det) state_d = START;
            START:   if (cnt == '0) state_d = rx_s ? IDLE : DATA;
            DATA:    if (cnt == '0 && bit_idx == 3'd7) state_d = STOP;
            STOP:    if (cnt == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        if (state_q == STOP && cnt == '0) begin
            byte_ok  = rx_s;
            byte_bad = ~rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (start_det) cnt <= HALF;
                START: begin
                    if (cnt == '0) begin
                        cnt     <= FULLB;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        cnt     <= FULLB;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: if (cnt != '0) cnt <= cnt - 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    assign a_rxdata = (peri_addr == BASE_ADDR + 32'h4);
    assign a_status = (peri_addr == BASE_ADDR + 32'h8);
    assign a_ctrl   = (peri_addr == BASE_ADDR + 32'hC);
    assign hit      = a_rxdata | a_status | a_ctrl;
    assign rd_acc   = peri_rden & ~pre_rden & hit;
    assign wr_acc   = peri_wren & ~pre_wren & hit;

    assign count       = wr_ptr - rd_ptr;
    assign nonempty    = (count != '0);
    assign full        = (count == (FIFO_AW + 1)'(DEPTH));
    assign pop         = rd_acc & a_rxdata & nonempty;
    // a pop in the same cycle frees the slot the incoming byte needs
    assign do_push     = byte_ok & (~full | pop);
    assign overrun_set = byte_ok & full & ~pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
    end

    always_comb begin
        rd_val = '0;
        if (a_rxdata && nonempty) rd_val = {1'b1, 23'b0, mem[rd_ptr[FIFO_AW-1:0]]};
        else if (a_status)        rd_val = {16'b0, 8'(count), 4'b0, frame_err, overrun, full, nonempty};
        else if (a_ctrl)          rd_val = {31'b0, irq_en};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            irq_en     <= 1'b0;
            irq_rx     <= 1'b0;
            pre_rden   <= 1'b0;
            pre_wren   <= 1'b0;
            peri_ready <= 1'b0;
            peri_rdata <= '0;
        end else begin
            wr_ptr     <= wr_ptr + (FIFO_AW + 1)'(do_push);
            rd_ptr     <= rd_ptr + (FIFO_AW + 1)'(pop);
            overrun    <= overrun_set | (overrun & ~(wr_acc & a_status & peri_wdata[2]));
            frame_err  <= byte_bad | (frame_err & ~(wr_acc & a_status & peri_wdata[3]));
            if (wr_acc && a_ctrl) irq_en <= peri_wdata[0];
            irq_rx     <= irq_en & nonempty;
            pre_rden   <= peri_rden;
            pre_wren   <= peri_wren;
            peri_ready <= rd_acc | wr_acc;
            peri_rdata <= rd_acc ? rd_val : '0;
        end
    end
endmodule

// File: tb/tb_uart_rx_peri.sv
// Directed-plus-random bench for uart_rx_peri with a queue-based model of the FIFO and sticky flags.
module tb_uart_rx_peri;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] A_RX = BASE + 32'h4;
    localparam logic [31:0] A_ST = BASE + 32'h8;
    localparam logic [31:0] A_CT = BASE + 32'hC;

    logic        clk, rst_n, uart_rx, peri_rden, peri_wren, peri_ready, irq_rx;
    logic [31:0] peri_addr, peri_wdata, peri_rdata;

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    logic       m_ov = 1'b0;
    logic       m_fe = 1'b0;

    uart_rx_peri #(.BAUD_DIV(16), .FIFO_AW(4), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .peri_rden(peri_rden), .peri_wren(peri_wren), .peri_addr(peri_addr),
        .peri_wdata(peri_wdata), .peri_rdata(peri_rdata), .peri_ready(peri_ready),
        .irq_rx(irq_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {16'b0, 8'(q.size()), 4'b0, m_fe, m_ov, q.size() == 16, q.size() != 0};
    endfunction

    function automatic logic [31:0] pop_model();
        if (q.size() == 0) return 32'h0;
        return {1'b1, 23'b0, q.pop_front()};
    endfunction

    // A frame received with a good stop bit lands in the FIFO unless it is already full.
    function automatic void rx_model(input logic [7:0] b, input logic stop);
        if (!stop)               m_fe = 1'b1;
        else if (q.size() == 16) m_ov = 1'b1;
        else                     q.push_back(b);
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (16) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic bus_read(input logic [31:0] addr, input int hold, output logic [31:0] data,
                            output int nrdy, output int lat, output logic [31:0] post_rd,
                            output logic post_irq);
        data = '0; nrdy = 0; lat = -1; post_rd = 32'hDEAD_BEEF; post_irq = 1'b1;
        peri_addr = addr;
        peri_rden = 1'b1;
        for (int i = 1; i <= hold + 3; i++) begin
            if (i == hold + 1) peri_rden = 1'b0;
            @(posedge clk); #1;
            if (peri_ready) begin
                nrdy++;
                data = peri_rdata;
                if (lat < 0) lat = i;
            end
            if (lat >= 0 && i == lat + 1) begin
                post_rd  = peri_rdata;
                post_irq = irq_rx;
            end
        end
        peri_rden = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wd, output int nrdy);
        nrdy = 0;
        peri_addr = addr; peri_wdata = wd; peri_wren = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) peri_wren = 1'b0;
            @(posedge clk); #1;
            if (peri_ready) nrdy++;
        end
        peri_wren = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d, pr;
        int n, l;
        logic pi;
        bus_read(addr, 1, d, n, l, pr, pi);
        chk(tag, d, exp);
        chk({tag, "_ack"}, 32'(n), 32'd1);
    endtask

    initial begin
        logic [31:0] d, pr;
        logic [7:0]  b, b2;
        logic        pi, r;
        int          n, l;

        rst_n = 1'b0; uart_rx = 1'b1; peri_rden = 1'b0; peri_wren = 1'b0;
        peri_addr = '0; peri_wdata = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_ready", {31'b0, peri_ready}, 32'd0);
        chk("rst_rdata", peri_rdata, 32'd0);
        chk("rst_irq", {31'b0, irq_rx}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        rd_chk("rst_status", A_ST, 32'd0);
        rd_chk("rst_ctrl", A_CT, 32'd0);

        // single byte, then latency and rdata-return-to-zero
        send_frame(8'hA5, 1'b1); rx_model(8'hA5, 1'b1);
        rd_chk("a5_status", A_ST, 32'h0000_0101);
        bus_read(A_RX, 1, d, n, l, pr, pi);
        chk("a5_data", d, 32'h8000_00A5);
        chk("a5_latency", 32'(l), 32'd1);
        chk("a5_post_rdata", pr, 32'd0);
        void'(pop_model());
        rd_chk("a5_status_after", A_ST, 32'd0);

        // back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1); rx_model(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1); rx_model(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1); rx_model(8'h3C, 1'b1);
        rd_chk("b2b_status", A_ST, exp_status());
        rd_chk("b2b_rx0", A_RX, 32'h8000_0000); void'(pop_model());
        rd_chk("b2b_rx1", A_RX, 32'h8000_00FF); void'(pop_model());
        rd_chk("b2b_rx2", A_RX, 32'h8000_003C); void'(pop_model());
        rd_chk("b2b_empty", A_RX, 32'd0);

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1); rx_model(b, 1'b1);
        end
        for (int i = 0; i < 4; i++) rd_chk("rand_rx", A_RX, pop_model());

        // overflow: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1); rx_model(b, 1'b1);
        end
        rd_chk("ovf_status", A_ST, exp_status());
        rd_chk("ovf_status_lit", A_ST, 32'h0000_1007);
        for (int i = 0; i < 16; i++) rd_chk("ovf_rx", A_RX, pop_model());
        bus_write(A_ST, 32'h4, n); m_ov = 1'b0;
        chk("ovf_clr_ack", 32'(n), 32'd1);
        rd_chk("ovf_cleared", A_ST, 32'd0);

        // framing error, then a short glitch on an idle line
        send_frame(8'h55, 1'b0); rx_model(8'h55, 1'b0);
        rd_chk("fe_status", A_ST, 32'h0000_0008);
        uart_rx = 1'b0; repeat (4) @(posedge clk); #1; uart_rx = 1'b1;
        repeat (40) @(posedge clk); #1;
        rd_chk("glitch_status", A_ST, 32'h0000_0008);
        bus_write(A_ST, 32'h8, n); m_fe = 1'b0;
        rd_chk("fe_cleared", A_ST, 32'd0);

        // interrupt set within two cycles of the stop sample, cleared after the emptying read
        bus_write(A_CT, 32'h1, n);
        rd_chk("ctrl_rb", A_CT, 32'd1);
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1);
            begin
                repeat (157) @(posedge clk); #1;
                chk("irq_set", {31'b0, irq_rx}, 32'd1);
            end
        join
        rx_model(b, 1'b1);
        bus_read(A_RX, 1, d, n, l, pr, pi);
        chk("irq_rx_data", d, pop_model());
        chk("irq_clear", {31'b0, pi}, 32'd0);

        // held read request pops exactly once
        b = 8'($urandom); b2 = 8'($urandom);
        send_frame(b, 1'b1); rx_model(b, 1'b1);
        send_frame(b2, 1'b1); rx_model(b2, 1'b1);
        bus_read(A_RX, 5, d, n, l, pr, pi);
        chk("hold_data", d, pop_model());
        chk("hold_pulses", 32'(n), 32'd1);
        rd_chk("hold_status", A_ST, exp_status());

        // unmapped addresses get no response; RXDATA writes are acked and ignored
        bus_read(BASE + 32'h10, 1, d, n, l, pr, pi);
        chk("unmap10_ack", 32'(n), 32'd0);
        chk("unmap10_rdata", d, 32'd0);
        bus_read(BASE, 1, d, n, l, pr, pi);
        chk("unmap0_ack", 32'(n), 32'd0);
        bus_write(A_RX, 32'hFFFF_FFFF, n);
        chk("wr_rx_ack", 32'(n), 32'd1);
        rd_chk("wr_rx_status", A_ST, exp_status());

        // reset in the middle of data bit 4
        chk("irq_pre_reset", {31'b0, irq_rx}, 32'd1);
        b = 8'($urandom);
        uart_rx = 1'b0; repeat (16) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            uart_rx = b[i]; repeat (16) @(posedge clk); #1;
        end
        uart_rx = b[4]; repeat (8) @(posedge clk); #1;
        rst_n = 1'b0; uart_rx = 1'b1; #2;
        chk("mid_rst_ready", {31'b0, peri_ready}, 32'd0);
        chk("mid_rst_rdata", peri_rdata, 32'd0);
        chk("mid_rst_irq", {31'b0, irq_rx}, 32'd0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete(); m_ov = 1'b0; m_fe = 1'b0;
        repeat (4) @(posedge clk); #1;
        rd_chk("post_rst_status", A_ST, 32'd0);
        rd_chk("post_rst_ctrl", A_CT, 32'd0);
        send_frame(8'h81, 1'b1); rx_model(8'h81, 1'b1);
        rd_chk("post_rst_rx", A_RX, 32'h8000_0081); void'(pop_model());

        // full FIFO: pop and push on the same edge
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1); rx_model(b, 1'b1);
        end
        b = 8'($urandom);
        d = '0; r = 1'b0;
        fork
            send_frame(b, 1'b1);
            begin
                repeat (154) @(posedge clk); #1;
                peri_addr = A_RX; peri_rden = 1'b1;
                @(posedge clk); #1;
                d = peri_rdata; r = peri_ready;
                peri_rden = 1'b0;
            end
        join
        chk("pp_data", d, pop_model());
        chk("pp_ack", {31'b0, r}, 32'd1);
        q.push_back(b);
        rd_chk("pp_status", A_ST, exp_status());
        rd_chk("pp_status_lit", A_ST, 32'h0000_1003);
        for (int i = 0; i < 16; i++) rd_chk("pp_rx", A_RX, pop_model());
        rd_chk("pp_final", A_ST, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
